width_converter_8ton: RTL and testbench
=======================================

WIDTH_CONVERTER_8TON -- requirements
Module: width_converter_8toN

Interface
REQ-001 Width: default 32; output word width in bits; SHALL be a multiple of 8 and >= 16; Bytes = Width/8.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 soft_reset_ni  input  1  synchronous active-low soft reset.
REQ-005 sink_valid_i  input  1  byte available from the I3C target FSM.
REQ-006 sink_ready_o  output  1  converter accepts a byte this cycle.
REQ-007 sink_data_i  input  8  incoming byte.
REQ-008 sink_flush_i  input  1  end-of-transfer pulse; emit any partial word.
REQ-009 source_valid_o  output  1  packed word available to the TTI RX queue.
REQ-010 source_ready_i  input  1  queue accepts the word.
REQ-011 source_data_o  output  Width  packed word; byte k at bits [8k+7:8k].
REQ-012 source_bytes_o  output  $clog2(Bytes)+1  count of valid bytes in source_data_o (1..Bytes while valid).

Function
REQ-013 State: byte counter bcnt (0..Bytes), Width-bit shift/assembly register sreg, output-valid flag.
REQ-014 sink_ready_o SHALL equal NOT source_valid_o (no byte accepted while a word is pending).
REQ-015 Byte accept (sink_valid_i & sink_ready_o): sink_data_i written to sreg byte lane bcnt, bcnt incremented; other lanes unchanged.
REQ-016 Packing SHALL be little-endian: first accepted byte of a word in bits [7:0].
REQ-017 Accepting byte number Bytes SHALL set source_valid_o on the next cycle with source_bytes_o = Bytes (1-cycle latency from last byte to valid).
REQ-018 Flush with source_valid_o low and bcnt > 0, or with a byte accepted in the same cycle: next cycle source_valid_o = 1, source_bytes_o = resulting byte count, unfilled lanes = 0.
REQ-019 Byte accept and flush in the same cycle: byte SHALL be included in the emitted word; if it completes the word, exactly one word with source_bytes_o = Bytes.
REQ-020 Flush with bcnt = 0 and no byte accepted: ignored, no word emitted.
REQ-021 Flush while source_valid_o high: ignored (accumulator holds no partial data then).
REQ-022 source_valid_o, source_data_o, source_bytes_o SHALL remain stable while source_valid_o & !source_ready_i.
REQ-023 Output handshake (source_valid_o & source_ready_i): next cycle source_valid_o = 0, bcnt = 0, sreg = 0, source_bytes_o = 0, sink_ready_o = 1.
REQ-024 Sustained throughput SHALL be Bytes bytes per Bytes+1 cycles when source_ready_i is held high.
REQ-025 source_bytes_o SHALL be 0 whenever source_valid_o is low.

Reset
REQ-026 rst_ni low: immediately, without clock, bcnt = 0, sreg = 0, source_valid_o = 0, source_data_o = 0, source_bytes_o = 0, sink_ready_o = 1.
REQ-027 soft_reset_ni low at a clock edge: same values as REQ-026 on that edge; takes priority over all handshakes and flush; pending words and partial bytes discarded.
REQ-028 Reset or soft reset mid-word: no partial word SHALL be emitted afterwards; next accepted byte lands in lane 0.

Verification (Width = 32)
REQ-029 Bytes 0x11,0x22,0x33,0x44 back-to-back, ready high -> one word 0x44332211, source_bytes_o = 4, valid 1 cycle after 4th byte.
REQ-030 Bytes 0xAA,0xBB then flush pulse -> word 0x0000BBAA, source_bytes_o = 2; following bytes start at lane 0.
REQ-031 Byte 0xDD with flush in same cycle after 0x11,0x22,0x33 -> single word 0xDD332211, source_bytes_o = 4; no extra empty word.
REQ-032 Full word with source_ready_i low 5 cycles, sink_valid_i held -> output stable, sink_ready_o = 0, no byte lost or overwritten; handshake then next byte in lane 0.
REQ-033 Flush with bcnt = 0 -> no source_valid_o; flush during pending word -> word unchanged, no second word.
REQ-034 rst_ni asserted asynchronously after 3 bytes, and soft_reset_ni low after 2 bytes -> all outputs at reset values; subsequent 4 bytes produce one correct word.

Source files
------------

// File: rtl/width_converter_8ton_if.sv
// Byte-in / word-out bus bundle for the 8-to-N width converter.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid high keeps
// its payload stable until that edge; ready may depend on the consumer's
// registered state only, never combinationally on valid.
interface width_converter_8ton_if #(
  parameter int Width = 32
);
  localparam int Bytes = Width / 8;
  localparam int CntW  = $clog2(Bytes) + 1;

  // byte side, fed by the I3C target FSM
  logic            sink_valid;
  logic            sink_ready;
  logic [7:0]      sink_data;
  logic            sink_flush;

  // word side, drained by the TTI RX queue
  logic            source_valid;
  logic            source_ready;
  logic [Width-1:0] source_data;
  logic [CntW-1:0]  source_bytes;

  // environment view: produces bytes, consumes words
  modport master (
    output sink_valid, sink_data, sink_flush, source_ready,
    input  sink_ready, source_valid, source_data, source_bytes
  );

  // converter view
  modport slave (
    input  sink_valid, sink_data, sink_flush, source_ready,
    output sink_ready, source_valid, source_data, source_bytes
  );
endinterface

// File: rtl/width_converter_8ton.sv
// Packs a stream of bytes little-endian into Width-bit words. A word is
// emitted when all lanes are filled or when a flush pulse ends a transfer
// with a partial word; unfilled lanes of a partial word read as zero.
// While a word is pending no byte is accepted, so the assembly register
// doubles as the output register.
module width_converter_8ton #(
  parameter int Width = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      soft_reset_ni,
  width_converter_8ton_if.slave     bus,
  output logic [$clog2(Width/8):0]  dbg_bcnt
);
  localparam int Bytes = Width / 8;
  localparam int CntW  = $clog2(Bytes) + 1;

  logic [CntW-1:0]  bcnt;
  logic [CntW-1:0]  bcnt_next;
  logic [Width-1:0] sreg;
  logic [Width-1:0] sreg_next;
  logic             valid;
  logic             accept;
  logic             emit;

  // Lane write for an accepted byte and the decision to present a word.
  always_comb begin
    accept    = bus.sink_valid & ~valid;
    bcnt_next = bcnt;
    sreg_next = sreg;
    emit      = 1'b0;
    if (accept) begin
      for (int k = 0; k < Bytes; k++) begin
        if (bcnt == CntW'(k)) begin
          sreg_next[8*k +: 8] = bus.sink_data;
        end
      end
      bcnt_next = bcnt + CntW'(1);
    end
    // A flush counts only if it leaves at least one byte to send; a byte
    // accepted alongside the flush is part of the same word.
    if (!valid) begin
      emit = (bcnt_next == CntW'(Bytes)) ||
             (bus.sink_flush && (bcnt_next != '0));
    end
  end

  // Accumulator and output-valid flag; soft reset outranks every handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt  <= '0;
      sreg  <= '0;
      valid <= 1'b0;
    end else if (!soft_reset_ni) begin
      bcnt  <= '0;
      sreg  <= '0;
      valid <= 1'b0;
    end else if (valid) begin
      if (bus.source_ready) begin
        bcnt  <= '0;
        sreg  <= '0;
        valid <= 1'b0;
      end
    end else begin
      bcnt  <= bcnt_next;
      sreg  <= sreg_next;
      valid <= emit;
    end
  end

  assign bus.sink_ready   = ~valid;
  assign bus.source_valid = valid;
  assign bus.source_data  = sreg;
  assign bus.source_bytes = valid ? bcnt : '0;
  assign dbg_bcnt         = bcnt;

endmodule

// File: tb/tb_width_converter_8ton.sv
// Directed bench for the 8-to-N width converter at Width = 32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_width_converter_8ton;
  localparam int Width = 32;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       soft_reset_ni;
  logic [2:0] dbg_bcnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  width_converter_8ton_if #(.Width(Width)) bus ();

  width_converter_8ton #(.Width(Width)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .soft_reset_ni (soft_reset_ni),
    .bus           (bus),
    .dbg_bcnt      (dbg_bcnt)
  );

  // clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // one byte offered for one cycle, optionally with flush
  task automatic push(input logic [7:0] b, input logic fl);
    bus.sink_valid = 1'b1;
    bus.sink_data  = b;
    bus.sink_flush = fl;
    @(negedge clk_i);
    bus.sink_valid = 1'b0;
    bus.sink_flush = 1'b0;
  endtask

  task automatic flush_pulse();
    bus.sink_flush = 1'b1;
    @(negedge clk_i);
    bus.sink_flush = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic [2:0] n);
    check({tag, "_valid"}, 64'(bus.source_valid), 64'd1);
    check({tag, "_data"},  64'(bus.source_data),  64'(d));
    check({tag, "_bytes"}, 64'(bus.source_bytes), 64'(n));
    check({tag, "_sready"}, 64'(bus.sink_ready), 64'd0);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 64'(bus.source_valid), 64'd0);
    check({tag, "_bytes"}, 64'(bus.source_bytes), 64'd0);
    check({tag, "_sready"}, 64'(bus.sink_ready), 64'd1);
  endtask

  initial begin
    logic [7:0] stream [8];
    int         idx;
    int         n_words;
    int         word_cyc [2];
    logic       acc;
    logic [31:0] exp_w;

    rst_ni           = 1'b0;
    soft_reset_ni    = 1'b1;
    bus.sink_valid   = 1'b0;
    bus.sink_data    = 8'h00;
    bus.sink_flush   = 1'b0;
    bus.source_ready = 1'b1;

    // reset values
    repeat (2) @(negedge clk_i);
    expect_idle("rst");
    check("rst_data", 64'(bus.source_data), 64'd0);
    check("rst_bcnt", 64'(dbg_bcnt), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // full word, back-to-back bytes
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    check("t1_pre_valid", 64'(bus.source_valid), 64'd0);
    check("t1_pre_bcnt", 64'(dbg_bcnt), 64'd3);
    push(8'h44, 1'b0);
    expect_word("t1", 32'h44332211, 3'd4);
    @(negedge clk_i);
    expect_idle("t1_after");
    check("t1_after_data", 64'(bus.source_data), 64'd0);

    // sustained throughput: 8 bytes streamed, two words 5 cycles apart
    stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    idx = 0;
    n_words = 0;
    word_cyc[0] = 0;
    word_cyc[1] = 0;
    for (int c = 0; c < 40 && n_words < 2; c++) begin
      bus.sink_valid = (idx < 8);
      if (idx < 8) bus.sink_data = stream[idx];
      acc = bus.sink_ready && (idx < 8);
      @(negedge clk_i);
      if (acc) idx++;
      if (bus.source_valid) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check("tp_word", 64'(bus.source_data), 64'(exp_w));
        word_cyc[n_words] = c;
        n_words++;
      end
    end
    bus.sink_valid = 1'b0;
    check("tp_nwords", 64'(n_words), 64'd2);
    check("tp_spacing", 64'(word_cyc[1] - word_cyc[0]), 64'd5);
    @(negedge clk_i);
    expect_idle("tp_after");

    // partial word by flush, next byte in lane 0
    push(8'hAA, 1'b0);
    push(8'hBB, 1'b0);
    flush_pulse();
    expect_word("t2", 32'h0000BBAA, 3'd2);
    @(negedge clk_i);
    push(8'h55, 1'b0);
    flush_pulse();
    expect_word("t2_lane0", 32'h00000055, 3'd1);
    @(negedge clk_i);

    // last byte with flush in the same cycle -> exactly one full word
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'hDD, 1'b1);
    expect_word("t3", 32'hDD332211, 3'd4);
    @(negedge clk_i);
    expect_idle("t3_after1");
    @(negedge clk_i);
    expect_idle("t3_after2");

    // backpressure with sink_valid held
    bus.source_ready = 1'b0;
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hA3, 1'b0);
    push(8'hA4, 1'b0);
    bus.sink_valid = 1'b1;
    bus.sink_data  = 8'hB5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      expect_word("t4_hold", 32'hA4A3A2A1, 3'd4);
    end
    bus.source_ready = 1'b1;
    @(negedge clk_i);
    expect_idle("t4_release");
    check("t4_release_bcnt", 64'(dbg_bcnt), 64'd0);
    bus.sink_flush = 1'b1;
    @(negedge clk_i);
    bus.sink_valid = 1'b0;
    bus.sink_flush = 1'b0;
    expect_word("t4_next", 32'h000000B5, 3'd1);
    @(negedge clk_i);

    // flush with empty accumulator is ignored
    flush_pulse();
    expect_idle("t5_empty1");
    @(negedge clk_i);
    expect_idle("t5_empty2");

    // flush while a word is pending is ignored
    bus.source_ready = 1'b0;
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b0);
    push(8'hC4, 1'b0);
    flush_pulse();
    expect_word("t5_pend", 32'hC4C3C2C1, 3'd4);
    bus.source_ready = 1'b1;
    @(negedge clk_i);
    expect_idle("t5_after1");
    @(negedge clk_i);
    expect_idle("t5_after2");

    // asynchronous reset after 3 bytes, between clock edges
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    expect_idle("t6_async");
    check("t6_async_data", 64'(bus.source_data), 64'd0);
    check("t6_async_bcnt", 64'(dbg_bcnt), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    expect_word("t6_post", 32'h04030201, 3'd4);
    @(negedge clk_i);

    // soft reset after 2 bytes
    push(8'h55, 1'b0);
    push(8'h66, 1'b0);
    soft_reset_ni = 1'b0;
    @(negedge clk_i);
    expect_idle("t6_soft");
    check("t6_soft_data", 64'(bus.source_data), 64'd0);
    check("t6_soft_bcnt", 64'(dbg_bcnt), 64'd0);
    soft_reset_ni = 1'b1;
    push(8'h9A, 1'b0);
    push(8'hBC, 1'b0);
    push(8'hDE, 1'b0);
    push(8'hF0, 1'b0);
    expect_word("t6_soft_post", 32'hF0DEBC9A, 3'd4);
    @(negedge clk_i);

    // soft reset beats a pending word, a byte and a flush
    bus.source_ready = 1'b0;
    push(8'h12, 1'b0);
    push(8'h34, 1'b0);
    push(8'h56, 1'b0);
    push(8'h78, 1'b0);
    soft_reset_ni  = 1'b0;
    bus.sink_valid = 1'b1;
    bus.sink_data  = 8'hEE;
    bus.sink_flush = 1'b1;
    @(negedge clk_i);
    bus.sink_valid = 1'b0;
    bus.sink_flush = 1'b0;
    soft_reset_ni  = 1'b1;
    expect_idle("t7_soft");
    check("t7_soft_bcnt", 64'(dbg_bcnt), 64'd0);
    bus.source_ready = 1'b1;
    @(negedge clk_i);
    expect_idle("t7_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
